mp_regfile_sb: RTL and testbench
================================

# mp_regfile_sb

Parametrised register file for the mp core. It provides NRP combinational read ports, two write ports (one for single-cycle units, one for long-latency LSU/sysbus returns) and a per-half-word scoreboard that flags reads of registers whose result is still outstanding. The core's hazard logic and forwarding registers consume the busy flags to stall issue.

## Interface
Parameters:
- NRP, 2, number of read ports (1..4)
- NPAIR, 16, number of 32-bit register pairs (power of two, 2..32); AW = $clog2(NPAIR)+1 is the half-register address width

Ports:
- sys_clk  in  1  core clock; all state updates on posedge
- sys_rst  in  1  reset, asynchronous, active-high
- rp_adr  in  NRP*AW  per-port half-register name; bit 0 selects the half, upper bits select the pair
- rp_data16  out  NRP*16  half read: adr[0] ? pair[31:16] : pair[15:0]
- rp_data32  out  NRP*32  pair read of adr[AW-1:1]
- rp_busy16  out  NRP  addressed half is pending
- rp_busy32  out  NRP  either half of the addressed pair is pending
- w0_en, w0_w32  in  1 each  port 0 write strobe and width (single-cycle units)
- w0_adr  in  AW  port 0 destination
- w0_data  in  32  port 0 data; bits [15:0] are used for a 16-bit write
- w1_en, w1_w32, w1_adr, w1_data  same as port 0; port 1 writes also clear the scoreboard
- rsv_en, rsv_w32  in  1 each  reserve the destination of an issuing long-latency op
- rsv_adr  in  AW  destination to reserve
- busy_vec  out  2*NPAIR  scoreboard, bit i = half i

## Operation
- Storage: NPAIR×32 flops, organised as 2*NPAIR halves. Half 0 is hardwired zero: it reads 0, is never written and is never busy. A 32-bit read of pair 0 returns {half1, 16'h0}.
- Write: w32 writes both halves of pair adr[AW-1:1] with data. Otherwise the half at adr is written with data[15:0]. Writes to half 0 are dropped.
- Write collision (w0 and w1 target the same half in the same cycle): w0 data wins per half. w1 still clears busy for the halves it addresses.
- Scoreboard: rsv sets busy for the addressed half, or for both halves if rsv_w32. A w1 write clears busy for the halves it writes. A w0 write does not touch busy.
- Set and clear of the same half in one cycle: the set wins, so the half stays busy because it has a new owner.
- A reserve of an already-busy half leaves it busy. Only one outstanding result per half is tracked.
- rp_busy32 = busy[2p] | busy[2p+1]. rp_busy16 = busy[adr].
- Reset: all registers, busy_vec, rp_busy16 and rp_busy32 are 0. All rp_data reads return 0 until the first write. A reset mid-operation discards all pending reservations.

## Timing
- Reads are combinational from rp_adr to rp_data and rp_busy, with zero-cycle latency.
- Writes and scoreboard updates take effect on the posedge of the cycle in which they are strobed.
- With the bypass enabled, a read in the same cycle returns the write data, and the busy flags are masked for halves cleared by w1 that cycle.
- The write-to-read bypass is per half, so a 16-bit write bypasses into a 32-bit read of the same pair, merged with the other, stored half.
- A reserve that targets a half whose w1 write arrives in the same cycle leaves the half busy from the next cycle onward.

## Configuration
- MP_REGFILE_BYPASS_EN
  - Defined: the write-through bypass and busy masking above are compiled in.
  - Undefined: reads return the pre-edge contents and busy state. The core must then cover the write cycle with its forwarding registers; the core's hazard logic accounts for the extra stall.

## Test plan
- Reset with sys_rst pulsed mid-run after rsv of half 5 → busy_vec=0 and every read returns 0.
- w0 32-bit write of 32'hDEAD_BEEF to adr 6, then read adr 6 and adr 7 (16-bit) and adr 6 (32-bit) → 16'hBEEF, 16'hDEAD and 32'hDEADBEEF.
- Writes of 16'h1234 to adr 0 and 16'h5678 to adr 1 → 16-bit read of adr 0 = 0, read of adr 1 = 16'h5678, 32-bit read of pair 0 = 32'h5678_0000.
- rsv 32-bit on adr 8, then a w1 16-bit write to adr 8 → rp_busy16(adr 8)=0 and rp_busy32=1 until a w1 write to adr 9.
- Same-cycle rsv and w1 clear on adr 10 → busy_vec[10]=1 after the edge. Same-cycle w0=16'hAAAA and w1=16'h5555 to adr 12 → the stored half is 16'hAAAA.
- With MP_REGFILE_BYPASS_EN defined, w0 write of 16'h00FF to adr 3 while reading adr 3 the same cycle → 16'h00FF. Without the macro → the old value, and 16'h00FF the next cycle.

Source files
------------

// File: rtl/mp_regfile_sb.sv
// mp core register file: NRP combinational read ports, two write ports and a per-half scoreboard.
// Optional same-cycle write-through bypass and busy masking: define MP_REGFILE_BYPASS_EN.
module mp_regfile_sb #(
    parameter int  NRP   = 2,
    parameter int  NPAIR = 16,
    localparam int AW    = $clog2(NPAIR) + 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NRP*AW-1:0]   rp_adr,
    output logic [NRP*16-1:0]   rp_data16,
    output logic [NRP*32-1:0]   rp_data32,
    output logic [NRP-1:0]      rp_busy16,
    output logic [NRP-1:0]      rp_busy32,
    input  logic                w0_en,
    input  logic                w0_w32,
    input  logic [AW-1:0]       w0_adr,
    input  logic [31:0]         w0_data,
    input  logic                w1_en,
    input  logic                w1_w32,
    input  logic [AW-1:0]       w1_adr,
    input  logic [31:0]         w1_data,
    input  logic                rsv_en,
    input  logic                rsv_w32,
    input  logic [AW-1:0]       rsv_adr,
    output logic [2*NPAIR-1:0]  busy_vec
);

    localparam int NH = 2 * NPAIR;

    logic [NH-1:0][15:0] half_q, half_d;
    logic [NH-1:0]       busy_q, busy_d;
    logic [NH-1:0]       clr_s, set_s;
    logic [NH-1:0][15:0] rd_half_s;
    logic [NH-1:0]       rd_busy_s;

    // A 32-bit access covers both halves of the pair named by adr[AW-1:1].
    function automatic logic hit_f(input logic en, input logic w32,
                                   input logic [AW-1:0] adr, input logic [AW-1:0] h);
        return en & (w32 ? (adr[AW-1:1] == h[AW-1:1]) : (adr == h));
    endfunction

    function automatic logic [15:0] wdata_f(input logic w32, input logic [31:0] d,
                                            input logic upper);
        return (w32 & upper) ? d[31:16] : d[15:0];
    endfunction

    // Next-state storage and scoreboard; w0 data overrides w1 data on a shared half.
    always_comb begin
        half_d = half_q;
        busy_d = busy_q;
        clr_s  = '0;
        set_s  = '0;
        for (int h = 1; h < NH; h++) begin
            clr_s[h]  = hit_f(w1_en, w1_w32, w1_adr, AW'(h));
            set_s[h]  = hit_f(rsv_en, rsv_w32, rsv_adr, AW'(h));
            half_d[h] = hit_f(w0_en, w0_w32, w0_adr, AW'(h)) ? wdata_f(w0_w32, w0_data, (h % 2) == 1)
                      : clr_s[h]                              ? wdata_f(w1_w32, w1_data, (h % 2) == 1)
                      :                                         half_q[h];
            // A new reservation outranks the clear from the previous owner's return.
            busy_d[h] = set_s[h] | (busy_q[h] & ~clr_s[h]);
        end
        half_d[0] = 16'h0;
        busy_d[0] = 1'b0;
    end

    // Storage and scoreboard state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            half_q <= '0;
            busy_q <= '0;
        end else begin
            half_q <= half_d;
            busy_q <= busy_d;
        end
    end

`ifdef MP_REGFILE_BYPASS_EN
    assign rd_half_s = half_d;
    assign rd_busy_s = busy_q & ~clr_s;
`else
    assign rd_half_s = half_q;
    assign rd_busy_s = busy_q;
`endif

    assign busy_vec = busy_q;

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        logic [AW-1:0] a_s, lo_s, hi_s;
        assign a_s  = rp_adr[p*AW +: AW];
        assign lo_s = {a_s[AW-1:1], 1'b0};
        assign hi_s = {a_s[AW-1:1], 1'b1};
        assign rp_data16[p*16 +: 16] = rd_half_s[a_s];
        assign rp_data32[p*32 +: 32] = {rd_half_s[hi_s], rd_half_s[lo_s]};
        assign rp_busy16[p]          = rd_busy_s[a_s];
        assign rp_busy32[p]          = rd_busy_s[hi_s] | rd_busy_s[lo_s];
    end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Self-checking bench for mp_regfile_sb: directed scenarios plus randomized traffic against a half-word model.
module tb_mp_regfile_sb;

    localparam int NRP   = 2;
    localparam int NPAIR = 16;
    localparam int AW    = 5;
    localparam int NH    = 32;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic [NRP*AW-1:0]  rp_adr;
    logic [NRP*16-1:0]  rp_data16;
    logic [NRP*32-1:0]  rp_data32;
    logic [NRP-1:0]     rp_busy16, rp_busy32;
    logic               w0_en, w0_w32, w1_en, w1_w32, rsv_en, rsv_w32;
    logic [AW-1:0]      w0_adr, w1_adr, rsv_adr;
    logic [31:0]        w0_data, w1_data;
    logic [2*NPAIR-1:0] busy_vec;

    int checks = 0;
    int errors = 0;

`ifdef MP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    mp_regfile_sb #(.NRP(NRP), .NPAIR(NPAIR)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rp_adr(rp_adr),
        .rp_data16(rp_data16), .rp_data32(rp_data32),
        .rp_busy16(rp_busy16), .rp_busy32(rp_busy32),
        .w0_en(w0_en), .w0_w32(w0_w32), .w0_adr(w0_adr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_w32(w1_w32), .w1_adr(w1_adr), .w1_data(w1_data),
        .rsv_en(rsv_en), .rsv_w32(rsv_w32), .rsv_adr(rsv_adr), .busy_vec(busy_vec)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: one entry per half-register.
    logic [15:0] mh [NH];
    logic        mb [NH];
    logic [15:0] nh [NH];
    logic        nb [NH];
    logic        clr [NH];

    function automatic bit covers(input bit en, input bit w32, input int adr, input int h);
        if (!en) return 1'b0;
        if (w32) return (adr / 2) == (h / 2);
        return adr == h;
    endfunction

    function automatic logic [15:0] half_of(input bit w32, input logic [31:0] d, input int h);
        if (w32 && (h % 2 == 1)) return d[31:16];
        return d[15:0];
    endfunction

    task automatic compute_next();
        for (int h = 0; h < NH; h++) begin
            nh[h] = mh[h]; nb[h] = mb[h]; clr[h] = 1'b0;
            if (h != 0) begin
                if (covers(w1_en, w1_w32, int'(w1_adr), h)) begin
                    nh[h] = half_of(w1_w32, w1_data, h);
                    clr[h] = 1'b1;
                    nb[h] = 1'b0;
                end
                if (covers(w0_en, w0_w32, int'(w0_adr), h)) nh[h] = half_of(w0_w32, w0_data, h);
                if (covers(rsv_en, rsv_w32, int'(rsv_adr), h)) nb[h] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            mh[h] = 16'h0; mb[h] = 1'b0;
        end
    endtask

    task automatic idle();
        w0_en = 1'b0; w0_w32 = 1'b0; w0_adr = '0; w0_data = 32'h0;
        w1_en = 1'b0; w1_w32 = 1'b0; w1_adr = '0; w1_data = 32'h0;
        rsv_en = 1'b0; rsv_w32 = 1'b0; rsv_adr = '0;
    endtask

    // Apply the current inputs across one posedge, advancing the model alongside.
    task automatic cycle();
        @(negedge sys_clk);
        compute_next();
        @(posedge sys_clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            mh[h] = nh[h]; mb[h] = nb[h];
        end
        idle();
    endtask

    task automatic wr0(input bit w32, input int adr, input logic [31:0] d);
        w0_en = 1'b1; w0_w32 = w32; w0_adr = AW'(adr); w0_data = d;
    endtask

    task automatic wr1(input bit w32, input int adr, input logic [31:0] d);
        w1_en = 1'b1; w1_w32 = w32; w1_adr = AW'(adr); w1_data = d;
    endtask

    task automatic rd(input int a0, input int a1);
        rp_adr = {AW'(a1), AW'(a0)};
    endtask

    task automatic test_reset();
        wr0(1'b1, 4, 32'h1357_2468);
        cycle();
        rsv_en = 1'b1; rsv_adr = AW'(5);
        cycle();
        checks++;
        if (busy_vec[5] !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy5: got %b expected 1", busy_vec[5]);
        end
        sys_rst = 1'b1;
        #2;
        sys_rst = 1'b0;
        model_reset();
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL rst_busy_vec: got %h expected 0", busy_vec);
        end
        for (int a = 0; a < NH; a++) begin
            rd(a, NH - 1 - a);
            #1;
            checks++;
            if (rp_data16 !== 32'h0 || rp_data32 !== 64'h0 || rp_busy16 !== 2'b0 || rp_busy32 !== 2'b0) begin
                errors++;
                $display("FAIL rst_read adr %0d: got d16=%h d32=%h b16=%b b32=%b expected all 0",
                         a, rp_data16, rp_data32, rp_busy16, rp_busy32);
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_w32();
        wr0(1'b1, 6, 32'hDEAD_BEEF);
        cycle();
        rd(6, 7);
        #2;
        checks++;
        if (rp_data16 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL w32_half_reads: got %h expected DEADBEEF", rp_data16);
        end
        checks++;
        if (rp_data32[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL w32_pair_read: got %h expected DEADBEEF", rp_data32[31:0]);
        end
    endtask

    task automatic test_half0();
        wr0(1'b0, 0, 32'h0000_1234);
        wr1(1'b0, 1, 32'h0000_5678);
        cycle();
        rd(0, 1);
        #2;
        checks++;
        if (rp_data16 !== 32'h5678_0000) begin
            errors++; $display("FAIL half0_reads: got %h expected 56780000", rp_data16);
        end
        checks++;
        if (rp_data32[31:0] !== 32'h5678_0000) begin
            errors++; $display("FAIL pair0_read: got %h expected 56780000", rp_data32[31:0]);
        end
        checks++;
        if (busy_vec[0] !== 1'b0) begin
            errors++; $display("FAIL half0_busy: got %b expected 0", busy_vec[0]);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_w32 = 1'b1; rsv_adr = AW'(8);
        cycle();
        wr1(1'b0, 8, 32'h0000_0808);
        cycle();
        rd(8, 9);
        #2;
        checks++;
        if (rp_busy16 !== 2'b10 || rp_busy32 !== 2'b11) begin
            errors++; $display("FAIL sb_partial_clear: got b16=%b b32=%b expected b16=10 b32=11", rp_busy16, rp_busy32);
        end
        wr1(1'b0, 9, 32'h0000_0909);
        cycle();
        rd(8, 9);
        #2;
        checks++;
        if (rp_busy16 !== 2'b00 || rp_busy32 !== 2'b00) begin
            errors++; $display("FAIL sb_full_clear: got b16=%b b32=%b expected 00 00", rp_busy16, rp_busy32);
        end
    endtask

    task automatic test_collision();
        rsv_en = 1'b1; rsv_adr = AW'(10);
        wr1(1'b0, 10, 32'h0000_1010);
        cycle();
        checks++;
        if (busy_vec[10] !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear: got %b expected 1", busy_vec[10]);
        end
        wr0(1'b0, 12, 32'h0000_AAAA);
        wr1(1'b0, 12, 32'h0000_5555);
        cycle();
        rd(12, 10);
        #2;
        checks++;
        if (rp_data16[15:0] !== 16'hAAAA) begin
            errors++; $display("FAIL w0_wins: got %h expected AAAA", rp_data16[15:0]);
        end
    endtask

    task automatic test_bypass();
        wr0(1'b0, 3, 32'h0000_1111);
        cycle();
        wr0(1'b0, 3, 32'h0000_00FF);
        rd(3, 2);
        #2;
        checks++;
        if (rp_data16[15:0] !== (BYP ? 16'h00FF : 16'h1111)) begin
            errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rp_data16[15:0], BYP ? 16'h00FF : 16'h1111);
        end
        cycle();
        #1;
        checks++;
        if (rp_data16[15:0] !== 16'h00FF) begin
            errors++; $display("FAIL bypass_next_cycle: got %h expected 00FF", rp_data16[15:0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] e16;
        logic [31:0] e32;
        logic        eb16, eb32;
        int          a, lo, hi;
        for (int n = 0; n < 400; n++) begin
            w0_en = ($urandom_range(0, 2) == 0); w0_w32 = $urandom_range(0, 1) == 1;
            w0_adr = AW'($urandom_range(0, NH - 1)); w0_data = $urandom;
            w1_en = ($urandom_range(0, 2) == 0); w1_w32 = $urandom_range(0, 1) == 1;
            w1_adr = ($urandom_range(0, 3) == 0) ? w0_adr : AW'($urandom_range(0, NH - 1));
            w1_data = $urandom;
            rsv_en = ($urandom_range(0, 2) == 0); rsv_w32 = $urandom_range(0, 1) == 1;
            rsv_adr = ($urandom_range(0, 3) == 0) ? w1_adr : AW'($urandom_range(0, NH - 1));
            rp_adr = ($urandom_range(0, 2) == 0) ? {w1_adr, w0_adr} : NRP*AW'($urandom);
            #2;
            compute_next();
            for (int p = 0; p < NRP; p++) begin
                a = int'(rp_adr[p*AW +: AW]);
                lo = a - (a % 2);
                hi = lo + 1;
                e16  = BYP ? nh[a] : mh[a];
                e32  = BYP ? {nh[hi], nh[lo]} : {mh[hi], mh[lo]};
                eb16 = mb[a] && !(BYP && clr[a]);
                eb32 = (mb[lo] && !(BYP && clr[lo])) || (mb[hi] && !(BYP && clr[hi]));
                checks++;
                if (rp_data16[p*16 +: 16] !== e16 || rp_data32[p*32 +: 32] !== e32 ||
                    rp_busy16[p] !== eb16 || rp_busy32[p] !== eb32) begin
                    errors++;
                    $display("FAIL rand_read n=%0d port %0d adr %0d: got %h/%h/%b/%b expected %h/%h/%b/%b",
                             n, p, a, rp_data16[p*16 +: 16], rp_data32[p*32 +: 32], rp_busy16[p], rp_busy32[p],
                             e16, e32, eb16, eb32);
                end
            end
            cycle();
            for (int h = 0; h < NH; h++) begin
                checks++;
                if (busy_vec[h] !== mb[h]) begin
                    errors++; $display("FAIL rand_busy_vec n=%0d half %0d: got %b expected %b", n, h, busy_vec[h], mb[h]);
                end
            end
        end
    endtask

    initial begin
        idle();
        rp_adr = '0;
        sys_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if (busy_vec !== 32'h0 || rp_data16 !== 32'h0 || rp_data32 !== 64'h0) begin
            errors++; $display("FAIL reset_state: got busy=%h d16=%h d32=%h expected 0", busy_vec, rp_data16, rp_data32);
        end
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        test_reset();
        test_w32();
        test_half0();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
